key_debounce_sched: RTL

//  Shares one debounce timer among NUM_KEYS raw push-button inputs (active-high, 1 = pressed).

---
 rtl/key_pkg.sv | 24 ++
 rtl/key_sync_2ff.sv | 24 ++
 rtl/key_debounce_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared constants, FSM state encoding and width helper for the key input blocks.
// Pure declarations: no latency, no backpressure.
package key_pkg;

  localparam int DEF_CLK_FREQ_HZ = 50_000_000;
  localparam int DEF_DEBOUNCE_MS = 20;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so that single-value fields still get a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/key_sync_2ff.sv
// Two-flop synchroniser for a vector of asynchronous key levels.
// Latency 2 cycles; no backpressure.
module key_sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_sched.sv
// One debounce timer shared round-robin by NUM_KEYS keys; commits a level and pulses press/release.
// Latency DEB_CYCLES+4 edges uncontended; no backpressure, pending keys simply wait for the timer.
module key_debounce_sched
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int DEB_CYCLES  = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NUM_KEYS-1:0]        key_in,
  output logic [NUM_KEYS-1:0]        key_status,
  output logic [NUM_KEYS-1:0]        key_press,
  output logic [NUM_KEYS-1:0]        key_release,
  output logic                       busy,
  output logic [clog2(NUM_KEYS)-1:0] grant_idx
);

  localparam int IDX_W = clog2(NUM_KEYS);
  localparam int CNT_W = clog2(DEB_CYCLES);

  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0] pending;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    next_idx;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_vld;
  logic [CNT_W-1:0]    cnt;
  state_t              state;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_KEYS) s = s - NUM_KEYS;
    return IDX_W'(s);
  endfunction

  key_sync_2ff #(
    .WIDTH (NUM_KEYS)
  ) u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (key_in),
    .q   (key_sync)
  );

  assign pending  = key_sync ^ key_status;
  assign next_idx = wrap_add(grant_idx, 1);

  // Walk from the farthest offset down so the first pending key at or after rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending[wrap_add(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      key_status  <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_idx <= pick_idx;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (key_sync[grant_idx] == key_status[grant_idx]) begin
            // Bounced back to the committed level: drop the window and move the pointer on.
            cnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_idx;
            state  <= ST_IDLE;
          end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            state <= ST_COMMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          // Guarded so a last-cycle bounce commits nothing and emits no pulse.
          if (key_sync[grant_idx] != key_status[grant_idx]) begin
            key_status[grant_idx] <= key_sync[grant_idx];
            if (key_sync[grant_idx]) key_press[grant_idx]   <= 1'b1;
            else                     key_release[grant_idx] <= 1'b1;
          end
          rr_ptr <= next_idx;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
